pc_fetch: RTL

Instruction-fetch front end that owns the architectural PC register and consumes the redirect target produced by the next-PC logic. It issues one instruction-memory read at a time over a valid/ready request channel and accepts the matching response. It forwards each instruction with its PC and PC+4 to decode through a one-entry output buffer. Redirects (taken branch, jump, jr) squash any in-flight fetch and restart at the new target.

---
 rtl/pc_fetch_pkg.sv | 24 ++
 rtl/fetch_out_buf.sv | 36 +++
 rtl/pc_fetch.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared fetch definitions: FSM encodings, reset PC and NPC control select.
package pc_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_DROP = 2'd2;
  localparam logic [1:0] FETCH_HOLD = 2'd3;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BRANCH,
    NPC_JUMP,
    NPC_JR
  } npc_sel_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready register stage carrying {instr, pc, misalign} to decode.
module fetch_out_buf
  import pc_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [XLEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pc,
  input  logic            d_misalign,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            misalign
);

  // Load wins over flush/consume so a new entry never leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc       <= '0;
      misalign <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= d_instr;
      pc       <= d_pc;
      misalign <= d_misalign;
    end else if (flush || ready) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, one-outstanding imem request FSM, output buffer.
// Optional PC_FETCH_ALIGN_CHECK_EN reports misaligned redirect targets instead of fetching them.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic [1:0]  dbg_state
`ifdef PC_FETCH_ALIGN_CHECK_EN
  ,
  output logic        if_misalign
`endif
);

  // Handshakes: a transfer happens in a cycle where valid & ready are both high;
  // once raised, imem_req_valid/imem_req_addr hold until that transfer.

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt, held_addr, held_nxt;
  logic        squash, squash_nxt, parked, parked_nxt;
  logic        buf_load, buf_flush, buf_d_mis;
  logic [31:0] buf_d_instr, buf_d_pc;
  logic        can_issue, req_fire, redir_mis;
  logic [31:0] redir_tgt;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign redir_mis = redir_valid & (redir_pc[1:0] != 2'b00);
  assign redir_tgt = redir_pc;
`else
  assign redir_mis = 1'b0;
  assign redir_tgt = redir_pc & ~32'h3;
`endif

  assign can_issue      = !if_valid || if_ready;
  // A squashed request must still complete, so squash keeps it on the bus.
  assign imem_req_valid = (state == FETCH_REQ) && (squash || (can_issue && !parked));
  assign imem_req_addr  = squash ? held_addr : pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign if_npc         = pc_plus4(if_pc);
  assign dbg_state      = state;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    held_nxt    = held_addr;
    squash_nxt  = squash;
    parked_nxt  = parked;
    buf_load    = 1'b0;
    buf_flush   = 1'b0;
    buf_d_instr = imem_rsp_data;
    buf_d_pc    = pc;
    buf_d_mis   = 1'b0;

    case (state)
      FETCH_REQ: begin
        if (req_fire) begin
          state_nxt  = squash ? FETCH_DROP : FETCH_WAIT;
          squash_nxt = 1'b0;
        end else if (!imem_req_valid) begin
          state_nxt = FETCH_HOLD;
        end
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          buf_load  = 1'b1;
          pc_nxt    = pc_plus4(pc);
          state_nxt = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (imem_rsp_valid) state_nxt = FETCH_REQ;
      end
      default: begin
        if (can_issue && !parked) state_nxt = FETCH_REQ;
      end
    endcase

    // Redirect overrides the buffer write and the sequential pc advance above.
    if (redir_valid) begin
      buf_flush   = 1'b1;
      buf_load    = redir_mis;
      buf_d_instr = '0;
      buf_d_pc    = redir_pc;
      buf_d_mis   = redir_mis;
      pc_nxt      = redir_tgt;
      parked_nxt  = redir_mis;
      case (state)
        FETCH_REQ: begin
          if (req_fire) begin
            state_nxt  = FETCH_DROP;
            squash_nxt = 1'b0;
          end else begin
            state_nxt = FETCH_REQ;
            if (imem_req_valid) begin
              squash_nxt = 1'b1;
              held_nxt   = imem_req_addr;
            end
          end
        end
        FETCH_WAIT: state_nxt = imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
        FETCH_DROP: state_nxt = imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
        default:    state_nxt = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_REQ;
      pc        <= RESET_PC;
      held_addr <= '0;
      squash    <= 1'b0;
      parked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      held_addr <= held_nxt;
      squash    <= squash_nxt;
      parked    <= parked_nxt;
    end
  end

  fetch_out_buf u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .flush      (buf_flush),
    .ready      (if_ready),
    .d_instr    (buf_d_instr),
    .d_pc       (buf_d_pc),
    .d_misalign (buf_d_mis),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc),
`ifdef PC_FETCH_ALIGN_CHECK_EN
    .misalign   (if_misalign)
`else
    .misalign   ()
`endif
  );

endmodule
